// File: rtl/pixel_packer_if.sv
// Pixel-in / word-out bundle for pixel_packer.
// slave: the packer side; master: the producer/consumer side.
interface pixel_packer_if;
    logic [1:0]  mode_i;
    logic [7:0]  pix_i;
    logic        pix_valid_i;
    logic        pix_ready_o;
    logic        flush_i;
    logic [15:0] dat_o;
    logic        dat_valid_o;
    logic        dat_ready_i;
    logic        overrun_o;

    modport slave (
        input  mode_i,
        input  pix_i,
        input  pix_valid_i,
        input  flush_i,
        input  dat_ready_i,
        output pix_ready_o,
        output dat_o,
        output dat_valid_o,
        output overrun_o
    );

    modport master (
        output mode_i,
        output pix_i,
        output pix_valid_i,
        output flush_i,
        output dat_ready_i,
        input  pix_ready_o,
        input  dat_o,
        input  dat_valid_o,
        input  overrun_o
    );
endinterface

// File: rtl/pixel_packer.sv
// pixel_packer: packs 1/2/4/8-bit pixels (one per dotclk) into 16-bit words and
// queues them in a small first-word-fall-through FIFO with valid/ready output.
// A flush request emits a partial word, zero-padded.
// Optional: define PIXEL_PACKER_LSB_FIRST_EN to pack the first pixel at bit 0
// (flushed words are then right-justified). Default is MSB-first.
module pixel_packer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic          dotclk_i,
    input  logic          reset_n_i,
    pixel_packer_if.slave bus
);
    localparam int unsigned CW = DEPTH_LOG2 + 1;

    // Packer state
    logic [15:0] acc_q, acc_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [1:0]  mode_q, mode_d;
    logic        flush_pend_q, flush_pend_d;
    logic        overrun_q, overrun_d;

    // FIFO state
    logic [15:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;

    // Datapath signals
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        pop;
    logic [1:0]  eff_mode;
    logic [4:0]  pix_n;
    logic [15:0] pix_bits;
    logic [4:0]  bitcnt_sum;
    logic [15:0] acc_packed;
    logic        word_done;
    logic        flush_exec;
    logic [15:0] flush_acc;
    logic [4:0]  flush_bits;
    logic [15:0] flush_word;
    logic        push;
    logic [15:0] push_data;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign accept     = bus.pix_valid_i && !fifo_full;
    assign pop        = !fifo_empty && bus.dat_ready_i;

    // Pixel width decode: mode_i only matters at the start of a word
    always_comb begin
        eff_mode = (bitcnt_q == 5'd0) ? bus.mode_i : mode_q;
        pix_n    = 5'd8;
        pix_bits = {8'd0, bus.pix_i};
        unique case (eff_mode)
            2'b00: begin
                pix_n    = 5'd1;
                pix_bits = {15'd0, bus.pix_i[0]};
            end
            2'b01: begin
                pix_n    = 5'd2;
                pix_bits = {14'd0, bus.pix_i[1:0]};
            end
            2'b10: begin
                pix_n    = 5'd4;
                pix_bits = {12'd0, bus.pix_i[3:0]};
            end
            2'b11: begin
                pix_n    = 5'd8;
                pix_bits = {8'd0, bus.pix_i};
            end
        endcase
    end

    // Shift the accepted pixel into the accumulator and build flush/push words
    always_comb begin
        bitcnt_sum = bitcnt_q + pix_n;
`ifdef PIXEL_PACKER_LSB_FIRST_EN
        acc_packed = (acc_q >> pix_n) | (pix_bits << (5'd16 - pix_n));
`else
        acc_packed = (acc_q << pix_n) | pix_bits;
`endif
        word_done  = accept && (bitcnt_sum == 5'd16);
        // A completing pixel takes the push slot; the flush waits a cycle
        flush_exec = flush_pend_q && !fifo_full && !word_done;
        // A pixel accepted alongside the flush joins the flushed word
        flush_acc  = accept ? acc_packed : acc_q;
        flush_bits = accept ? bitcnt_sum : bitcnt_q;
`ifdef PIXEL_PACKER_LSB_FIRST_EN
        flush_word = flush_acc >> (5'd16 - flush_bits);
`else
        flush_word = flush_acc << (5'd16 - flush_bits);
`endif
        push       = word_done || (flush_exec && (flush_bits != 5'd0));
        push_data  = word_done ? acc_packed : flush_word;
    end

    // Packer next-state: accumulator, bit count, latched mode, flush and overrun flags
    always_comb begin
        acc_d        = acc_q;
        bitcnt_d     = bitcnt_q;
        mode_d       = mode_q;
        flush_pend_d = flush_pend_q;
        overrun_d    = overrun_q;

        if (accept && (bitcnt_q == 5'd0)) begin
            mode_d = bus.mode_i;
        end

        if (word_done || flush_exec) begin
            acc_d    = '0;
            bitcnt_d = '0;
        end else if (accept) begin
            acc_d    = acc_packed;
            bitcnt_d = bitcnt_sum;
        end

        if (flush_exec) begin
            flush_pend_d = 1'b0;
        end
        if (bus.flush_i) begin
            flush_pend_d = 1'b1;
        end

        if (bus.pix_valid_i && fifo_full) begin
            overrun_d = 1'b1;
        end
    end

    // FIFO occupancy next-state; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Packer and FIFO control registers
    always_ff @(posedge dotclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q        <= '0;
            bitcnt_q     <= '0;
            mode_q       <= 2'b00;
            flush_pend_q <= 1'b0;
            overrun_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            acc_q        <= acc_d;
            bitcnt_q     <= bitcnt_d;
            mode_q       <= mode_d;
            flush_pend_q <= flush_pend_d;
            overrun_q    <= overrun_d;
            count_q      <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
        end
    end

    // FIFO storage; contents are only observable through count, so no reset
    always_ff @(posedge dotclk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign bus.pix_ready_o = !fifo_full;
    assign bus.dat_valid_o = !fifo_empty;
    assign bus.dat_o       = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];
    assign bus.overrun_o   = overrun_q;

    // Pushes are gated by !full, so the FIFO can never overflow
    a_no_push_full: assert property (@(posedge dotclk_i) disable iff (!reset_n_i)
        !(push && fifo_full));
    a_count_range: assert property (@(posedge dotclk_i) disable iff (!reset_n_i)
        count_q <= CW'(DEPTH));
    a_bitcnt_range: assert property (@(posedge dotclk_i) disable iff (!reset_n_i)
        bitcnt_q < 5'd16);

endmodule

// File: tb/tb_pixel_packer.sv
// Self-checking bench for pixel_packer: directed vectors plus a model-driven
// random phase, with a scoreboard of expected words compared on each pop.
module tb_pixel_packer;
    logic clk;
    logic rst_n;
    logic dir_ready;
    logic rnd_ready;
    logic rnd_en;

    int n_checks;
    int n_fail;

    logic [15:0] sb [$];

    // Bench-side packing model (used in the random phase)
    int m_bits;
    int m_mode;
    int m_word;

`ifdef PIXEL_PACKER_LSB_FIRST_EN
    localparam logic [15:0] W_ABCD = 16'hCDAB;
    localparam logic [15:0] W_2BPP = 16'h4F93;
    localparam logic [15:0] W_FLSH = 16'h0CBA;
    localparam logic [15:0] W_MODE = 16'h8765;
    localparam logic [15:0] W_NEXT = 16'hBC9A;
    localparam logic [15:0] W_1234 = 16'h4321;
    localparam logic [15:0] W_BP0  = 16'h0201;
    localparam logic [15:0] W_BP1  = 16'h0403;
    localparam logic [15:0] W_BP2  = 16'h0605;
    localparam logic [15:0] W_BP3  = 16'h0807;
`else
    localparam logic [15:0] W_ABCD = 16'hABCD;
    localparam logic [15:0] W_2BPP = 16'hC6F1;
    localparam logic [15:0] W_FLSH = 16'hABC0;
    localparam logic [15:0] W_MODE = 16'h5678;
    localparam logic [15:0] W_NEXT = 16'h9ABC;
    localparam logic [15:0] W_1234 = 16'h1234;
    localparam logic [15:0] W_BP0  = 16'h0102;
    localparam logic [15:0] W_BP1  = 16'h0304;
    localparam logic [15:0] W_BP2  = 16'h0506;
    localparam logic [15:0] W_BP3  = 16'h0708;
`endif

    pixel_packer_if pp_if ();

    assign pp_if.dat_ready_i = rnd_en ? rnd_ready : dir_ready;

    pixel_packer #(
        .DEPTH      (4),
        .DEPTH_LOG2 (2)
    ) u_dut (
        .dotclk_i  (clk),
        .reset_n_i (rst_n),
        .bus       (pp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, ending 1 time unit after a rising edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_pix(input logic [1:0] m, input logic [7:0] p);
        int n;
        int pv;
        if (m_bits == 0) m_mode = int'(m);
        n  = 1 << m_mode;
        pv = int'(p) & ((1 << n) - 1);
`ifdef PIXEL_PACKER_LSB_FIRST_EN
        m_word = m_word | (pv << m_bits);
`else
        m_word = m_word | (pv << (16 - m_bits - n));
`endif
        m_bits = m_bits + n;
        if (m_bits == 16) begin
            sb.push_back(m_word[15:0]);
            m_word = 0;
            m_bits = 0;
        end
    endtask

    task automatic model_flush();
        if (m_bits != 0) sb.push_back(m_word[15:0]);
        m_word = 0;
        m_bits = 0;
    endtask

    // Offer one pixel until accepted (bounded); optionally feed the model
    task automatic drive_pix(input logic [1:0] m, input logic [7:0] p, input bit use_model);
        bit taken;
        int guard;
        taken = 1'b0;
        guard = 0;
        pp_if.mode_i      = m;
        pp_if.pix_i       = p;
        pp_if.pix_valid_i = 1'b1;
        while (!taken && guard < 200) begin
            @(negedge clk);
            taken = pp_if.pix_ready_o;
            @(posedge clk);
            #1;
            guard++;
        end
        pp_if.pix_valid_i = 1'b0;
        if (!taken) check_eq("pix_accept_timeout", 32'(guard), 32'(0));
        else if (use_model) model_pix(m, p);
    endtask

    task automatic pulse_flush();
        pp_if.flush_i = 1'b1;
        step(1);
        pp_if.flush_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 400) begin
            step(1);
            guard++;
        end
        check_eq(tag, 32'(sb.size()), 32'(0));
    endtask

    // Scoreboard: compare each popped word against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && pp_if.dat_valid_o && pp_if.dat_ready_i) begin
            if (sb.size() == 0) check_eq("sb_occupancy", 32'(sb.size()), 32'(1));
            else check_eq("word", {16'd0, pp_if.dat_o}, {16'd0, sb.pop_front()});
        end
    end

    initial begin
        rnd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        m_bits            = 0;
        m_mode            = 0;
        m_word            = 0;
        rst_n             = 1'b0;
        rnd_en            = 1'b0;
        dir_ready         = 1'b0;
        pp_if.mode_i      = 2'b00;
        pp_if.pix_i       = 8'h00;
        pp_if.pix_valid_i = 1'b0;
        pp_if.flush_i     = 1'b0;

        // Reset state
        step(2);
        check_eq("rst_dat_valid", 32'(pp_if.dat_valid_o), 32'(0));
        check_eq("rst_dat", 32'(pp_if.dat_o), 32'(0));
        check_eq("rst_pix_ready", 32'(pp_if.pix_ready_o), 32'(1));
        check_eq("rst_overrun", 32'(pp_if.overrun_o), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // 8bpp: word appears one dotclk after the completing accept, for one cycle
        dir_ready = 1'b1;
        sb.push_back(W_ABCD);
        drive_pix(2'b11, 8'hAB, 1'b0);
        drive_pix(2'b11, 8'hCD, 1'b0);
        @(negedge clk);
        check_eq("lat_valid", 32'(pp_if.dat_valid_o), 32'(1));
        check_eq("lat_dat", 32'(pp_if.dat_o), 32'(W_ABCD));
        @(negedge clk);
        check_eq("lat_one_cycle", 32'(pp_if.dat_valid_o), 32'(0));
        step(1);

        // 2bpp packing order
        sb.push_back(W_2BPP);
        foreach (W_2BPP[i]) begin end
        begin
            logic [7:0] px [8];
            px = '{8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd0, 8'd1};
            for (int i = 0; i < 8; i++) drive_pix(2'b01, px[i], 1'b0);
        end
        wait_drain("drain_2bpp");

        // 4bpp partial word flush, then a no-op flush
        sb.push_back(W_FLSH);
        drive_pix(2'b10, 8'h0A, 1'b0);
        drive_pix(2'b10, 8'h0B, 1'b0);
        drive_pix(2'b10, 8'h0C, 1'b0);
        pulse_flush();
        wait_drain("drain_flush");
        step(2);
        pulse_flush();
        step(4);
        check_eq("noop_flush_valid", 32'(pp_if.dat_valid_o), 32'(0));

        // Backpressure: fill FIFO, overrun, then drain in order
        dir_ready = 1'b0;
        sb.push_back(W_BP0);
        sb.push_back(W_BP1);
        sb.push_back(W_BP2);
        sb.push_back(W_BP3);
        for (int k = 1; k <= 8; k++) drive_pix(2'b11, 8'(k), 1'b0);
        @(negedge clk);
        check_eq("bp_ready_low", 32'(pp_if.pix_ready_o), 32'(0));
        check_eq("bp_overrun_pre", 32'(pp_if.overrun_o), 32'(0));
        @(posedge clk);
        #1;
        pp_if.pix_i       = 8'h09;
        pp_if.pix_valid_i = 1'b1;
        step(1);
        pp_if.pix_valid_i = 1'b0;
        @(negedge clk);
        check_eq("bp_overrun", 32'(pp_if.overrun_o), 32'(1));
        step(1);
        dir_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_ready_after_pop", 32'(pp_if.pix_ready_o), 32'(1));
        step(1);
        wait_drain("drain_bp");

        // Mode change mid-word is ignored; next word starts in the new mode
        sb.push_back(W_MODE);
        sb.push_back(W_NEXT);
        drive_pix(2'b10, 8'h05, 1'b0);
        drive_pix(2'b11, 8'h06, 1'b0);
        drive_pix(2'b11, 8'h07, 1'b0);
        drive_pix(2'b11, 8'h08, 1'b0);
        drive_pix(2'b11, 8'h9A, 1'b0);
        drive_pix(2'b11, 8'hBC, 1'b0);
        wait_drain("drain_mode");

        // Asynchronous reset mid-word with two words queued
        dir_ready = 1'b0;
        for (int k = 0; k < 10; k++) drive_pix(2'b10, 8'(k + 3), 1'b0);
        @(negedge clk);
        check_eq("pre_rst_valid", 32'(pp_if.dat_valid_o), 32'(1));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_dat_valid", 32'(pp_if.dat_valid_o), 32'(0));
        check_eq("arst_dat", 32'(pp_if.dat_o), 32'(0));
        check_eq("arst_pix_ready", 32'(pp_if.pix_ready_o), 32'(1));
        check_eq("arst_overrun", 32'(pp_if.overrun_o), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        dir_ready = 1'b1;
        sb.push_back(W_1234);
        for (int k = 1; k <= 4; k++) drive_pix(2'b10, 8'(k), 1'b0);
        wait_drain("drain_1234");

        // Random phase against the bench model, random consumer stalls
        rnd_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            drive_pix(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b1);
            if (i % 11 == 10) begin
                step(1);
                pulse_flush();
                model_flush();
                step(20);
            end
        end
        step(1);
        pulse_flush();
        model_flush();
        step(20);
        rnd_en    = 1'b0;
        dir_ready = 1'b1;
        wait_drain("drain_random");
        @(negedge clk);
        check_eq("final_empty", 32'(pp_if.dat_valid_o), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
